instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
// Parametrised fetch stage for the RISC-V core: owns the fetch PC and issues in-order reads to instruction memory.
// Responses are buffered in a FETCH_QUEUE_DEPTH-entry {pc,instr} FIFO feeding decode over a valid/ready handshake.
// A redirect (branch/jump/trap) flushes the queue and silently drops every response still in flight.
// Sits between the PC source (execute/trap redirect) and the decode stage.
// PARAMETERS
// ADDRESS_WIDTH     32      width of PC and memory address
// DATA_WIDTH        32      instruction word width; PC step = DATA_WIDTH/8
// RESET_VECTOR      32'h0   first fetch address after reset
// FETCH_QUEUE_DEPTH 4       queue entries and max in-flight credit; power of 2, >=2
// PORTS
// CLK             in   1              clock, all state on rising edge
// RESET           in   1              asynchronous, active-high reset
// IMEM_REQ_VALID  out  1              read request valid
// IMEM_REQ_ADDR   out  ADDRESS_WIDTH  read address (fetch PC)
// IMEM_REQ_READY  in   1              memory accepts request this cycle
// IMEM_RSP_VALID  in   1              read data valid; responses return in request order
// IMEM_RSP_DATA   in   DATA_WIDTH     instruction word
// REDIRECT_VALID  in   1              redirect fetch; single-cycle pulse, may repeat
// REDIRECT_PC     in   ADDRESS_WIDTH  new fetch PC; low log2(DATA_WIDTH/8) bits forced to 0
// IF_VALID        out  1              queue head valid to decode
// IF_INSTRUCTION  out  DATA_WIDTH     queue head instruction
// IF_PC           out  ADDRESS_WIDTH  queue head PC
// ID_READY        in   1              decode consumes head when IF_VALID & ID_READY
// BEHAVIOUR
// - Reset: fetch_pc=rsp_pc=RESET_VECTOR; queue count, outstanding, discard all 0; IMEM_REQ_VALID=0, IF_VALID=0.
// - Request fire = IMEM_REQ_VALID & IMEM_REQ_READY. IMEM_REQ_VALID = !REDIRECT_VALID & (count+outstanding < DEPTH).
//   On fire fetch_pc += DATA_WIDTH/8 (wraps mod 2^ADDRESS_WIDTH); while unaccepted, IMEM_REQ_ADDR is stable.
//   VALID may drop without acceptance only in a redirect cycle; memory side tolerates this.
// - outstanding: +1 on fire, -1 on IMEM_RSP_VALID, net 0 when both occur in the same cycle; never exceeds DEPTH.
// - Response handling: if discard!=0 or REDIRECT_VALID, data dropped and discard-- (when discard!=0);
//   else {rsp_pc,data} written to queue tail, rsp_pc += DATA_WIDTH/8. Written entry visible next cycle (no bypass).
// - Credit rule guarantees no write when full; write into full queue is an assertion failure.
// - Queue: simultaneous write and read allowed at any occupancy, including full; count unchanged.
// - IF_VALID = (count!=0) & !REDIRECT_VALID; outputs driven from head entry; head stable while IF_VALID & !ID_READY.
// - Redirect at cycle t (registered at edge ending t):
//   - queue count <- 0; pops/pushes of cycle t are void.
//   - fetch_pc <- REDIRECT_PC and rsp_pc <- REDIRECT_PC.
//   - discard <- outstanding - IMEM_RSP_VALID. Nothing fires in t, so this counts every request still in flight.
//   - t+1: IMEM_REQ_VALID with REDIRECT_PC if credit allows.
//   - If memory accepts in t+1 and responds in t+2: IF_VALID in t+3 with IF_PC=REDIRECT_PC.
// - Back-to-back redirects: the later wins; discard is recomputed from the current outstanding each time.
// - Reset mid-operation clears all state immediately. Instruction memory is reset by the same RESET,
//   so no stale responses follow.
// - Decode stall (ID_READY=0): queue fills, then requests stop once count+outstanding reach DEPTH. No data lost.
// TESTING
// - Reset, memory always ready, 1-cycle response, ID_READY=1 -> IF_PC 0,4,8,... one per cycle after fill; no gaps.
// - ID_READY=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, IF_VALID held, IF_PC=0 stable.
//   Release -> PCs 0,4,8,12,16 in order.
// - Redirect to 0x100 with 2 requests outstanding -> next 2 responses dropped; IF_PC=0x100 first.
//   No PC from old stream reaches decode.
// - Redirect with REDIRECT_PC=0x102 -> fetch address 0x100.
//   Redirects in consecutive cycles to 0x200 then 0x300 -> only 0x300 stream delivered.
// - IMEM_REQ_READY toggled randomly, response latency 1-3 cycles -> IMEM_REQ_ADDR stable while unaccepted.
//   Instruction stream identical to the ideal-memory run; outstanding never >4.
// - RESET asserted mid-stream for 1 cycle -> all outputs 0 immediately; first new request at RESET_VECTOR.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch_unit
// Brief   : In-order instruction fetch with a credit-limited {pc,instr} queue
// Revision: 1.0
// ============================================================================
module instruction_fetch_unit #(
  parameter int unsigned              ADDRESS_WIDTH     = 32,
  parameter int unsigned              DATA_WIDTH        = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR      = '0,
  parameter int unsigned              FETCH_QUEUE_DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  output logic                     IMEM_REQ_VALID,
  output logic [ADDRESS_WIDTH-1:0] IMEM_REQ_ADDR,
  input  logic                     IMEM_REQ_READY,
  input  logic                     IMEM_RSP_VALID,
  input  logic [DATA_WIDTH-1:0]    IMEM_RSP_DATA,
  input  logic                     REDIRECT_VALID,
  input  logic [ADDRESS_WIDTH-1:0] REDIRECT_PC,
  output logic                     IF_VALID,
  output logic [DATA_WIDTH-1:0]    IF_INSTRUCTION,
  output logic [ADDRESS_WIDTH-1:0] IF_PC,
  input  logic                     ID_READY
);

  localparam int unsigned c_PTR_W   = $clog2(FETCH_QUEUE_DEPTH);
  localparam int unsigned c_CNT_W   = c_PTR_W + 1;
  localparam int unsigned c_ENTRY_W = ADDRESS_WIDTH + DATA_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] c_PC_STEP    = ADDRESS_WIDTH'(DATA_WIDTH / 8);
  localparam logic [ADDRESS_WIDTH-1:0] c_ALIGN_MASK = ~(c_PC_STEP - ADDRESS_WIDTH'(1));
  localparam logic [c_CNT_W-1:0]       c_DEPTH      = c_CNT_W'(FETCH_QUEUE_DEPTH);

  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [c_CNT_W-1:0]       count_q, count_d;
  logic [c_CNT_W-1:0]       outstanding_q, outstanding_d;
  logic [c_CNT_W-1:0]       discard_q, discard_d;
  logic [c_PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [c_ENTRY_W-1:0]     mem_q [FETCH_QUEUE_DEPTH];

  logic                     w_credit_ok;
  logic                     w_req_fire;
  logic                     w_discarding;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_not_empty;
  logic [c_ENTRY_W-1:0]     w_head;
  logic [c_CNT_W:0]         w_in_use;
  logic [ADDRESS_WIDTH-1:0] w_redirect_pc;

  // Queue slots plus requests in flight may never exceed the queue size,
  // so every response is guaranteed a slot when it returns.
  assign w_in_use    = {1'b0, count_q} + {1'b0, outstanding_q};
  assign w_credit_ok = w_in_use < {1'b0, c_DEPTH};

  assign IMEM_REQ_VALID = !RESET && !REDIRECT_VALID && w_credit_ok;
  assign IMEM_REQ_ADDR  = fetch_pc_q;
  assign w_req_fire     = IMEM_REQ_VALID && IMEM_REQ_READY;

  assign w_discarding  = discard_q != '0;
  assign w_push        = IMEM_RSP_VALID && !w_discarding && !REDIRECT_VALID;
  assign w_not_empty   = count_q != '0;
  assign w_pop         = IF_VALID && ID_READY;
  assign w_redirect_pc = REDIRECT_PC & c_ALIGN_MASK;

  assign w_head         = mem_q[rd_ptr_q];
  assign IF_VALID       = w_not_empty && !REDIRECT_VALID;
  assign IF_PC          = w_not_empty ? w_head[c_ENTRY_W-1 -: ADDRESS_WIDTH] : '0;
  assign IF_INSTRUCTION = w_not_empty ? w_head[DATA_WIDTH-1:0] : '0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (REDIRECT_VALID) begin
      // Nothing fires during a redirect, so every live request must be dropped.
      fetch_pc_d    = w_redirect_pc;
      rsp_pc_d      = w_redirect_pc;
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      outstanding_d = outstanding_q - c_CNT_W'(IMEM_RSP_VALID);
      discard_d     = outstanding_q - c_CNT_W'(IMEM_RSP_VALID);
    end else begin
      if (w_req_fire) begin
        fetch_pc_d = fetch_pc_q + c_PC_STEP;
      end
      outstanding_d = outstanding_q + c_CNT_W'(w_req_fire) - c_CNT_W'(IMEM_RSP_VALID);
      if (IMEM_RSP_VALID && w_discarding) begin
        discard_d = discard_q - c_CNT_W'(1);
      end
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        rsp_pc_d = rsp_pc_q + c_PC_STEP;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
      end
      count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_pc_q    <= RESET_VECTOR;
      rsp_pc_q      <= RESET_VECTOR;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage is masked by the count, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {rsp_pc_q, IMEM_RSP_DATA};
    end
  end

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (!RESET) begin
      assert (!(w_push && !w_pop && count_q == c_DEPTH));
      assert (outstanding_q <= c_DEPTH);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_instruction_fetch_unit
// Brief   : Directed + random bench with in-order memory and stream model
// Revision: 1.0
// ============================================================================
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IMEM_REQ_VALID;
  logic [31:0] IMEM_REQ_ADDR;
  logic        IMEM_REQ_READY = 1'b0;
  logic        IMEM_RSP_VALID = 1'b0;
  logic [31:0] IMEM_RSP_DATA = '0;
  logic        REDIRECT_VALID = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        IF_VALID;
  logic [31:0] IF_INSTRUCTION;
  logic [31:0] IF_PC;
  logic        ID_READY = 1'b0;

  instruction_fetch_unit #(
    .ADDRESS_WIDTH    (32),
    .DATA_WIDTH       (32),
    .RESET_VECTOR     (32'h0),
    .FETCH_QUEUE_DEPTH(4)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .IMEM_REQ_VALID(IMEM_REQ_VALID),
    .IMEM_REQ_ADDR (IMEM_REQ_ADDR),
    .IMEM_REQ_READY(IMEM_REQ_READY),
    .IMEM_RSP_VALID(IMEM_RSP_VALID),
    .IMEM_RSP_DATA (IMEM_RSP_DATA),
    .REDIRECT_VALID(REDIRECT_VALID),
    .REDIRECT_PC   (REDIRECT_PC),
    .IF_VALID      (IF_VALID),
    .IF_INSTRUCTION(IF_INSTRUCTION),
    .IF_PC         (IF_PC),
    .ID_READY      (ID_READY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    mq[$];
  logic [31:0] popped[$];
  int          cyc = 0;
  int          last_due = 0;
  int          checks = 0;
  int          errors = 0;
  int          fires = 0;
  bit          rdy_rand = 1'b0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          idr_mode = 1;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_req = '0;
  bit          prev_req_wait = 1'b0;
  bit          prev_if_hold = 1'b0;
  logic [31:0] prev_req_addr = '0;
  logic [31:0] prev_if_pc = '0;
  logic        s_req_valid, s_if_valid, s_fire;
  logic [31:0] s_req_addr, s_if_pc, s_if_instr;
  bit          found;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive memory/decode inputs, sample at negedge, update model.
  task automatic tick();
    int lat;
    int due;
    if (!RESET && mq.size() > 0 && mq[0].due <= cyc) begin
      IMEM_RSP_VALID = 1'b1;
      IMEM_RSP_DATA  = instr_of(mq[0].addr);
    end else begin
      IMEM_RSP_VALID = 1'b0;
      IMEM_RSP_DATA  = $urandom;
    end
    IMEM_REQ_READY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    ID_READY = (idr_mode == 2) ? ($urandom_range(0, 3) != 0) : (idr_mode != 0);
    @(negedge CLK);
    s_req_valid = IMEM_REQ_VALID;
    s_req_addr  = IMEM_REQ_ADDR;
    s_if_valid  = IF_VALID;
    s_if_pc     = IF_PC;
    s_if_instr  = IF_INSTRUCTION;
    s_fire      = IMEM_REQ_VALID & IMEM_REQ_READY;
    if (RESET) begin
      mq.delete();
      last_due      = cyc;
      exp_pc        = 32'h0;
      exp_req       = 32'h0;
      prev_req_wait = 1'b0;
      prev_if_hold  = 1'b0;
    end else begin
      if (IMEM_RSP_VALID) void'(mq.pop_front());
      if (prev_req_wait && !REDIRECT_VALID) begin
        chk("req_valid_held", {31'b0, s_req_valid}, 32'h1);
        chk("req_addr_stable", s_req_addr, prev_req_addr);
      end
      if (prev_if_hold && !REDIRECT_VALID) begin
        chk("if_valid_held", {31'b0, s_if_valid}, 32'h1);
        chk("if_pc_stable", s_if_pc, prev_if_pc);
      end
      if (s_if_valid && ID_READY) begin
        chk("if_pc", s_if_pc, exp_pc);
        chk("if_instr", s_if_instr, instr_of(exp_pc));
        popped.push_back(s_if_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (s_fire) begin
        chk("req_addr", s_req_addr, exp_req);
        exp_req = exp_req + 32'd4;
        lat = $urandom_range(lat_min, lat_max);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{addr: s_req_addr, due: due});
        fires++;
      end
      chk("outstanding_le_4", {31'b0, (mq.size() <= 4)}, 32'h1);
      if (REDIRECT_VALID) begin
        exp_pc  = REDIRECT_PC & ~32'h3;
        exp_req = REDIRECT_PC & ~32'h3;
      end
      prev_req_wait = s_req_valid & ~IMEM_REQ_READY;
      prev_req_addr = s_req_addr;
      prev_if_hold  = s_if_valid & ~ID_READY;
      prev_if_pc    = s_if_pc;
    end
    @(posedge CLK);
    #1;
    cyc++;
    REDIRECT_VALID = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int i = 0; i < budget && popped.size() < n; i++) tick();
    chk("pop_wait_budget", {31'b0, (popped.size() >= n)}, 32'h1);
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_req_valid", {31'b0, s_req_valid}, 32'h0);
    chk("rst_if_valid", {31'b0, s_if_valid}, 32'h0);
    chk("rst_req_addr", s_req_addr, 32'h0);

    // Ideal memory, one instruction per cycle after the pipeline fills
    RESET = 1'b0;
    tick();
    chk("first_fire", {31'b0, s_fire}, 32'h1);
    chk("first_addr", s_req_addr, 32'h0);
    tick();
    tick();
    chk("first_if_valid", {31'b0, s_if_valid}, 32'h1);
    chk("first_if_pc", s_if_pc, 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("no_gap", {31'b0, s_if_valid}, 32'h1);
    end

    // Decode stall: exactly DEPTH requests, head held
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    idr_mode = 0;
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 3) begin
        chk("stall_if_valid", {31'b0, s_if_valid}, 32'h1);
        chk("stall_if_pc", s_if_pc, 32'h0);
      end
    end
    chk("stall_fires", fires, 32'd4);
    popped.delete();
    idr_mode = 1;
    wait_pops(5, 20);
    for (int k = 0; k < 5; k++) chk("release_order", popped[k], 32'(4 * k));

    // Redirect with two requests in flight
    lat_min = 3;
    lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (mq.size() == 2) found = 1'b1;
    end
    chk("two_outstanding", {31'b0, found}, 32'h1);
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h100;
    tick();
    chk("redirect_blocks_req", {31'b0, s_req_valid}, 32'h0);
    chk("redirect_blocks_if", {31'b0, s_if_valid}, 32'h0);
    popped.delete();
    wait_pops(3, 30);
    chk("redir_first_pc", popped[0], 32'h100);

    // Unaligned redirect, then back-to-back redirects
    lat_min = 1;
    lat_max = 1;
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h102;
    tick();
    tick();
    chk("aligned_req_valid", {31'b0, s_req_valid}, 32'h1);
    chk("aligned_req_addr", s_req_addr, 32'h100);
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h200;
    tick();
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h300;
    tick();
    popped.delete();
    tick();
    chk("b2b_req_addr", s_req_addr, 32'h300);
    wait_pops(2, 30);
    chk("b2b_first_pc", popped[0], 32'h300);

    // PC wraps around the top of the address space
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'hFFFF_FFF8;
    tick();
    popped.delete();
    wait_pops(4, 30);
    chk("wrap_pc0", popped[0], 32'hFFFF_FFF8);
    chk("wrap_pc2", popped[2], 32'h0000_0000);
    chk("wrap_pc3", popped[3], 32'h0000_0004);

    // Random ready, latency 1-3, random decode stalls and redirects
    rdy_rand = 1'b1;
    lat_min  = 1;
    lat_max  = 3;
    idr_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC    = 32'($urandom_range(0, 32'hFFFF));
      end
      tick();
    end

    // Reset mid-stream
    RESET = 1'b1;
    tick();
    chk("midrst_req_valid", {31'b0, s_req_valid}, 32'h0);
    chk("midrst_if_valid", {31'b0, s_if_valid}, 32'h0);
    chk("midrst_if_pc", s_if_pc, 32'h0);
    chk("midrst_if_instr", s_if_instr, 32'h0);
    chk("midrst_req_addr", s_req_addr, 32'h0);
    RESET = 1'b0;
    rdy_rand = 1'b0;
    tick();
    chk("post_rst_fire", {31'b0, s_fire}, 32'h1);
    chk("post_rst_addr", s_req_addr, 32'h0);
    rdy_rand = 1'b1;
    for (int i = 0; i < 200; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
